shift_unit_arbiter: RTL
=======================

// Module: shift_unit_arbiter
// PURPOSE
//  Shares one 64-bit shift datapath (existing ShiftL64U + ShiftR64U) between two requesters.
//  Round-robin arbitration, multi-cycle sequencing and a registered result with valid/ready backpressure.
//  Sits between the two execution clients (req0, req1) and a single response consumer.
// PARAMETERS
//  DW    64  data width; only 64 is supported, because the shifters are fixed-width
//  NW    8   shift-amount width; matches the shifter n input
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req0_valid   in   1   requester 0 has a command
//  req0_ready   out  1   requester 0 command accepted this cycle
//  req0_op      in   2   00 SLL, 01 SRL, 10 ROL, 11 ROR
//  req0_n       in   NW  shift amount
//  req0_data    in   DW  operand
//  req1_*       ...      same set of ports for requester 1
//  rsp_valid    out  1   result available
//  rsp_ready    in   1   consumer takes result
//  rsp_id       out  1   index of the requester that owns the result
//  rsp_data     out  DW  result
//  rsp_err      out  1   unsupported op
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset: state=IDLE, last_grant=1 (so req0 wins first), rsp_valid/rsp_id/rsp_data/rsp_err=0.
//    No handshake is taken while rst_n=0.
//  - FSM: IDLE -> SHIFT -> [ROT] -> RESP -> IDLE.
//  - IDLE, grant:
//    - reqX_ready = (state==IDLE) & grant==X.
//    - If both requesters are valid, grant goes to !last_grant. Otherwise grant goes to the sole valid requester.
//  - IDLE, accept (valid&ready in cycle C): latch op, n, data and id; set last_grant=id; go to SHIFT.
//  - SHIFT (C+1):
//    - SLL: acc = shl(data,n). SRL: acc = shr(data,n). For n>=64 the result is 0.
//    - ROL: acc = shl(data,k). ROR: acc = shr(data,k). Here k = n[5:0]; the go to ROT.
//    - Otherwise go to RESP.
//  - ROT (C+2): ROL: acc |= shr(data, 64-k). ROR: acc |= shl(data, 64-k).
//    64-k is computed at 8 bits, so k=0 gives 64 and the partial result is 0; the result is then data.
//  - Latency: rsp_valid is high from cycle C+2 (SLL/SRL) or C+3 (rotate).
//  - RESP: rsp_valid=1. rsp_id, rsp_data and rsp_err stay stable until rsp_ready.
//    On rsp_valid&rsp_ready: go to IDLE and drop rsp_valid on the next edge.
//  - No new accept in the same cycle as a response handshake. Peak throughput: 1 op per 3 cycles (SLL/SRL).
//  - req_* inputs are sampled only at accept; later changes have no effect on the op in flight.
//  - Reset mid-operation clears state at once. The in-flight op is dropped and never answered.
// CONFIGURATION
//  - SHIFT_ARB_ROT_EN defined: ROL/ROR are supported as above; rsp_err is always 0. ROT state is present.
//  - SHIFT_ARB_ROT_EN undefined: ROT state and rotate logic are absent.
//    op[1]=1 goes SHIFT->RESP with rsp_data=0, rsp_err=1 at C+2.
//    SLL/SRL behaviour and timing are unchanged.
// STRUCTURE
//  - Shared header ShiftDefs.v holds:
//    - op codes: SHOP_SLL=2'b00, SHOP_SRL=2'b01, SHOP_ROL=2'b10, SHOP_ROR=2'b11
//    - FSM state encodings: ST_IDLE, ST_SHIFT, ST_ROT, ST_RESP
//  - Sub-module shift_rr_arb2: combinational 2-way round-robin grant from (valid[1:0], last_grant).
//  - One ShiftL64U and one ShiftR64U instance. Their n/in inputs are muxed by state; no other shifter copies.
// TESTING
//  1. req0 SLL, data=0x1, n=4 accepted cycle C -> rsp_valid at C+2, rsp_data=0x10, rsp_id=0, rsp_err=0.
//  2. req1 SRL, data=0xFFFF_FFFF_FFFF_FFFF, n=0x40 -> rsp_data=0, rsp_id=1.
//     Repeat with n=0x3F -> rsp_data=0x1.
//  3. After reset, both requesters valid continuously with SLL n=1, rsp_ready=1 -> grants in order
//     req0, req1, req0, req1; each accept 3 cycles apart.
//  4. ROL, data=0x8000_0000_0000_0001, n=1 -> with ROT_EN: rsp_data=0x3 at C+3.
//     ROR with n=0 -> data unchanged.
//     Without ROT_EN: rsp_err=1, rsp_data=0 at C+2.
//  5. rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data and rsp_err stable; both req_ready=0.
//     Release -> IDLE on the next edge.
//  6. rst_n low during SHIFT -> rsp_valid=0 immediately. After release no response appears and req0 wins first.

Source files
------------

// File: rtl/shift_unit_arbiter_pkg.sv
// Shared op codes and FSM state encodings for the shared 64-bit shift unit.
// Imported by the arbiter top; holds no logic.
package shift_unit_arbiter_pkg;

    localparam int SH_DW = 64;
    localparam int SH_NW = 8;

    typedef enum logic [1:0] {
        SHOP_SLL = 2'b00,
        SHOP_SRL = 2'b01,
        SHOP_ROL = 2'b10,
        SHOP_ROR = 2'b11
    } shop_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_ROT   = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/ShiftL64U.sv
// Fixed-width 64-bit logical left shifter; amounts of 64 or more give zero.
// Combinational, no flow control.
module ShiftL64U (
    input  logic [63:0] din,
    input  logic [7:0]  n,
    output logic [63:0] dout
);
    assign dout = (n >= 8'd64) ? 64'd0 : (din << n[5:0]);
endmodule

// File: rtl/ShiftR64U.sv
// Fixed-width 64-bit logical right shifter; amounts of 64 or more give zero.
// Combinational, no flow control.
module ShiftR64U (
    input  logic [63:0] din,
    input  logic [7:0]  n,
    output logic [63:0] dout
);
    assign dout = (n >= 8'd64) ? 64'd0 : (din >> n[5:0]);
endmodule

// File: rtl/shift_rr_arb2.sv
// Two-way round-robin grant: contention goes to the requester that did not win last.
// Combinational, no flow control.
module shift_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant
);
    always_comb begin
        grant = !last_grant;
        if (valid == 2'b01)
            grant = 1'b0;
        else if (valid == 2'b10)
            grant = 1'b1;
    end
endmodule

// File: rtl/shift_unit_arbiter.sv
// Two requesters share one left and one right 64-bit shifter; SHIFT_ARB_ROT_EN enables ROL/ROR.
// Latency: response valid 2 cycles after accept (SLL/SRL/unsupported), 3 cycles for rotates.
// Backpressure: result held in RESP until rsp_ready; no command is accepted outside IDLE.
import shift_unit_arbiter_pkg::*;

module shift_unit_arbiter #(
    parameter int DW = 64,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [1:0]    req0_op,
    input  logic [NW-1:0] req0_n,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [1:0]    req1_op,
    input  logic [NW-1:0] req1_n,
    input  logic [DW-1:0] req1_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err
);
    state_t        state;
    shop_t         op_q;
    logic [NW-1:0] n_q;
    logic [DW-1:0] data_q;
    logic          id_q;
    logic          last_grant;
    logic          grant;
    logic          take0, take1;
    logic          op_right, op_rot;
    logic [NW-1:0] sh_n;
    logic [DW-1:0] shl_out, shr_out;

    shift_rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is gated by rst_n so that no handshake can complete while held in reset.
    assign req0_ready = rst_n && (state == ST_IDLE) && !grant;
    assign req1_ready = rst_n && (state == ST_IDLE) &&  grant;
    assign take0      = req0_valid && req0_ready;
    assign take1      = req1_valid && req1_ready;

    assign op_right = (op_q == SHOP_SRL) || (op_q == SHOP_ROR);
    assign op_rot   = (op_q == SHOP_ROL) || (op_q == SHOP_ROR);

`ifdef SHIFT_ARB_ROT_EN
    logic [DW-1:0] acc;
    logic [NW-1:0] rot_k;
    assign rot_k = {2'b00, n_q[5:0]};

    // Rotate = shift by k, then OR in the opposite shift by 64-k; k=0 makes the second term 0.
    always_comb begin
        sh_n = n_q;
        if (op_rot)
            sh_n = (state == ST_ROT) ? (8'd64 - rot_k) : rot_k;
    end
`else
    assign sh_n = n_q;
`endif

    ShiftL64U u_shl (.din(data_q), .n(sh_n), .dout(shl_out));
    ShiftR64U u_shr (.din(data_q), .n(sh_n), .dout(shr_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= SHOP_SLL;
            n_q        <= '0;
            data_q     <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
`ifdef SHIFT_ARB_ROT_EN
            acc        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take0 || take1) begin
                        op_q       <= shop_t'(take1 ? req1_op : req0_op);
                        n_q        <= take1 ? req1_n    : req0_n;
                        data_q     <= take1 ? req1_data : req0_data;
                        id_q       <= take1;
                        last_grant <= take1;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (op_rot) begin
`ifdef SHIFT_ARB_ROT_EN
                        acc   <= op_right ? shr_out : shl_out;
                        state <= ST_ROT;
`else
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
`endif
                    end else begin
                        rsp_data  <= op_right ? shr_out : shl_out;
                        rsp_err   <= 1'b0;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
`ifdef SHIFT_ARB_ROT_EN
                ST_ROT: begin
                    rsp_data  <= acc | (op_right ? shl_out : shr_out);
                    rsp_err   <= 1'b0;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
